// File: rtl/led_frame_ctrl.sv
// Double-buffered 4x8 frame store for the LED matrix driver.
// Two requesters fill the back buffer, and a commit copies it to the front buffer at a frame boundary.
module led_frame_ctrl #(
    parameter int FRAME_CYCLES = 4096
) (
    input  logic       clk12MHz,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [1:0] a_row,
    input  logic [7:0] a_data,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [1:0] b_row,
    input  logic [7:0] b_data,
    input  logic       commit,
    output logic       commit_pending,
    output logic       swapped,
    output logic       frame_start,
    output logic [7:0] leds1,
    output logic [7:0] leds2,
    output logic [7:0] leds3,
    output logic [7:0] leds4
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] counter;
    logic          last_grant;  // 0 = A, 1 = B
    logic [7:0]    back [4];
    logic          wr_en;
    logic [1:0]    wr_row;
    logic [7:0]    wr_data;
    logic          copy;

    // Back buffer is frozen while a commit waits, so the copied frame is exactly what was committed.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!commit_pending) begin
            a_ready = a_valid && (!b_valid || last_grant);
            b_ready = b_valid && (!a_valid || !last_grant);
        end
    end

    always_comb begin
        wr_en   = a_ready || b_ready;
        wr_row  = a_ready ? a_row  : b_row;
        wr_data = a_ready ? a_data : b_data;
    end

    assign copy        = commit_pending && (counter == LAST);
    assign frame_start = (counter == '0);

    always_ff @(posedge clk12MHz) begin
        if (!rst_n) begin
            counter        <= '0;
            last_grant     <= 1'b1;
            commit_pending <= 1'b0;
            swapped        <= 1'b0;
            leds1          <= '0;
            leds2          <= '0;
            leds3          <= '0;
            leds4          <= '0;
            for (int i = 0; i < 4; i++) back[i] <= '0;
        end else begin
            counter <= (counter == LAST) ? '0 : counter + 1'b1;
            swapped <= copy;
            if (wr_en) begin
                back[wr_row] <= wr_data;
                last_grant   <= b_ready;
            end
            if (copy)
                commit_pending <= 1'b0;
            else if (commit)
                commit_pending <= 1'b1;
            if (copy) begin
                leds1 <= back[0];
                leds2 <= back[1];
                leds3 <= back[2];
                leds4 <= back[3];
            end
        end
    end

endmodule
